branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-stage producer for the branch target buffer's update port.
- Compares the IF-time prediction carried with each control-transfer instruction against its resolved outcome.
- Issues registered BTB updates, a one-cycle mispredict redirect to IF, and wrong-path suppression.
- Keeps saturating performance counters for resolved control transfers and mispredictions.

Parameters:
- XLEN, 32, address/data width.
- DRAIN_CYCLES, 2, cycles after a redirect during which incoming EX instructions are wrong-path and ignored (1..7).
- UPDATE_JALR, 1, when 1, JALR resolutions write the BTB; when 0, they never do.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  EX holds a valid control-transfer instruction (branch/JAL/JALR).
- i_stall  in  1  EX stalled; the instruction is not accepted this cycle.
- i_flush  in  1  older-instruction flush (trap/exception); kills the current EX instruction.
- i_is_jalr  in  1  instruction is JALR.
- i_is_compressed  in  1  16-bit instruction.
- i_pc  in  XLEN  instruction PC.
- i_btb_hit  in  1  BTB hit recorded at IF.
- i_predicted_taken  in  1  IF prediction.
- i_predicted_target  in  XLEN  IF predicted target.
- i_actual_taken  in  1  resolved direction (1 for JAL/JALR).
- i_actual_target  in  XLEN  resolved target.
- o_update  out  1  BTB update strobe.
- o_update_pc  out  XLEN  BTB update PC.
- o_update_target  out  XLEN  BTB update target.
- o_update_taken  out  1  BTB update outcome.
- o_mispredict  out  1  redirect strobe to IF.
- o_redirect_pc  out  XLEN  correct fetch PC.
- o_busy_drain  out  1  high while in DRAIN.
- o_cf_count  out  32  accepted control transfers, saturating.
- o_mispredict_count  out  32  mispredictions, saturating.

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE. Reset has priority over every other input.
- Accept in cycle T when i_valid && !i_stall && !i_flush && state==IDLE. A stalled instruction is accepted exactly once, on its first unstalled cycle.
- Fallthrough = i_pc + 2 if i_is_compressed, else i_pc + 4; modulo 2^XLEN (wraps past 0xFFFF_FFFF).
- Mispredict when predicted_taken != actual_taken, or both are taken and predicted_target != actual_target.
- Redirect PC = i_actual_target if actual_taken, else fallthrough.
- Update condition for an accepted instruction: (actual_taken || i_btb_hit) && !(i_is_jalr && UPDATE_JALR==0). Not-taken branches that missed the BTB never allocate.
- Update fields: o_update_pc = i_pc, o_update_target = i_actual_target, o_update_taken = i_actual_taken.
- Latency: o_update* and o_mispredict/o_redirect_pc are registered and appear in cycle T+1 for exactly one cycle. Both strobes may assert in the same cycle.
- Strobe fields: when o_update is 0, o_update_* hold their last values. When o_mispredict is 0, o_redirect_pc holds its last value.
- State machine:
  - IDLE -> DRAIN on an accepted mispredict at T. State is DRAIN from T+1; o_busy_drain = 1.
  - DRAIN counts DRAIN_CYCLES cycles (T+1 .. T+DRAIN_CYCLES), then returns to IDLE. The 3-bit down-counter loads DRAIN_CYCLES-1.
  - In DRAIN, i_valid is ignored: no update, no mispredict, no counter increment. Wrong-path mispredicts are dropped.
  - The counter decrements during DRAIN whether or not i_stall is high.
- i_flush at T: no acceptance at T, o_update = o_mispredict = 0 at T+1, state forced to IDLE (aborts DRAIN), drain counter cleared. Strobes registered from T-1 still present during T.
- Counters: o_cf_count increments on every acceptance. o_mispredict_count increments on every accepted mispredict. Both visible at T+1 and hold at 0xFFFF_FFFF.
- Reset mid-DRAIN: state IDLE next cycle, outputs 0.

Test Plan:
- Correct prediction: pc 0x100, btb_hit=1, pred taken/0x200, actual taken/0x200 -> T+1 o_update=1, pc 0x100, target 0x200, taken 1; o_mispredict=0; cf_count=1.
- Direction mispredict: pc 0x100, compressed, pred taken, actual not-taken, btb_hit=1 -> T+1 o_mispredict=1, redirect 0x102, update taken 0. Valid instructions at T+1, T+2 are ignored (o_busy_drain=1); the instruction at T+3 is accepted.
- Target mispredict, plus BTB-miss not-taken: JALR pc 0x40, pred taken/0x80, actual 0x90 -> redirect 0x90, mispredict_count=1. With UPDATE_JALR=0: o_update=0. Separately, a not-taken branch with btb_hit=0 and correct prediction -> no update, cf_count increments.
- Stall then flush: valid with i_stall=1 for 3 cycles, then released -> exactly one update. Mispredict at T with i_flush=1 -> no strobes at T+1, state IDLE. i_flush during DRAIN -> next valid accepted immediately.
- Wrap: pc 0xFFFF_FFFC, non-compressed, pred taken, actual not-taken -> redirect 0x0000_0000.
- Saturation and reset: force o_cf_count to 0xFFFF_FFFF, accept one more -> holds. Assert i_rst mid-DRAIN -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// EX-stage resolver for control-transfer instructions. It compares the
// prediction made at IF with the resolved outcome. From that it produces:
//   - a registered BTB update,
//   - a one-cycle redirect strobe back to IF,
//   - a DRAIN window that discards wrong-path instructions,
//   - saturating counters for control transfers and mispredictions.
//
// Handshake: an EX instruction transfers in a cycle when i_valid is high,
// i_stall is low, i_flush is low and the unit is IDLE. i_stall acts as
// "not ready", so a stalled instruction is held by EX and transfers exactly
// once, on its first unstalled cycle. Both strobes (o_update, o_mispredict)
// are single-cycle pulses one cycle after the transfer. Their payload
// fields hold their last value while the strobe is low.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid/i_stall/i_flush  EX instruction qualifiers
//   i_is_jalr, i_is_compressed, i_pc   instruction info
//   i_btb_hit, i_predicted_taken, i_predicted_target   IF prediction
//   i_actual_taken, i_actual_target    resolved outcome
//   o_update, o_update_pc/target/taken BTB update port
//   o_mispredict, o_redirect_pc        redirect to IF
//   o_busy_drain                       high while in DRAIN (state visible)
//   o_cf_count, o_mispredict_count     saturating performance counters
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter bit UPDATE_JALR  = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_is_jalr,
    input  logic            i_is_compressed,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_btb_hit,
    input  logic            i_predicted_taken,
    input  logic [XLEN-1:0] i_predicted_target,
    input  logic            i_actual_taken,
    input  logic [XLEN-1:0] i_actual_target,
    output logic            o_update,
    output logic [XLEN-1:0] o_update_pc,
    output logic [XLEN-1:0] o_update_target,
    output logic            o_update_taken,
    output logic            o_mispredict,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_busy_drain,
    output logic [31:0]     o_cf_count,
    output logic [31:0]     o_mispredict_count
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // The counter runs DRAIN_LOAD..0, which gives DRAIN_CYCLES cycles in DRAIN.
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    logic [0:0]      state_q;
    logic [2:0]      drain_cnt_q;
    logic [31:0]     cf_count_q;
    logic [31:0]     mispredict_count_q;

    logic            accept;
    logic            mispredict;
    logic            do_update;
    logic [XLEN-1:0] fallthrough;
    logic [XLEN-1:0] redirect_pc;

    assign accept = i_valid && !i_stall && !i_flush && (state_q == ST_IDLE);

    // The addition is modulo 2^XLEN, so a PC at the top of the address space
    // falls through to address 0.
    assign fallthrough = i_pc + (i_is_compressed ? XLEN'(2) : XLEN'(4));

    // A target compare matters only when both the prediction and the
    // outcome are taken. A not-taken outcome ignores any stale target.
    assign mispredict = (i_predicted_taken != i_actual_taken) ||
                        (i_predicted_taken && i_actual_taken &&
                         (i_predicted_target != i_actual_target));

    assign redirect_pc = i_actual_taken ? i_actual_target : fallthrough;

    // A not-taken branch that missed the BTB never allocates an entry.
    assign do_update = accept && (i_actual_taken || i_btb_hit) &&
                       !(i_is_jalr && !UPDATE_JALR);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q            <= ST_IDLE;
            drain_cnt_q        <= '0;
            o_update           <= 1'b0;
            o_update_pc        <= '0;
            o_update_target    <= '0;
            o_update_taken     <= 1'b0;
            o_mispredict       <= 1'b0;
            o_redirect_pc      <= '0;
            cf_count_q         <= '0;
            mispredict_count_q <= '0;
        end else begin
            o_update     <= do_update;
            o_mispredict <= accept && mispredict;

            if (do_update) begin
                o_update_pc     <= i_pc;
                o_update_target <= i_actual_target;
                o_update_taken  <= i_actual_taken;
            end

            if (accept && mispredict) begin
                o_redirect_pc <= redirect_pc;
            end

            if (accept && (cf_count_q != 32'hFFFF_FFFF)) begin
                cf_count_q <= cf_count_q + 32'd1;
            end

            if (accept && mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
                mispredict_count_q <= mispredict_count_q + 32'd1;
            end

            // A flush from an older instruction aborts any drain window.
            // The DRAIN counter runs regardless of i_stall.
            if (i_flush) begin
                state_q     <= ST_IDLE;
                drain_cnt_q <= '0;
            end else if (state_q == ST_DRAIN) begin
                if (drain_cnt_q == 3'd0) begin
                    state_q <= ST_IDLE;
                end else begin
                    drain_cnt_q <= drain_cnt_q - 3'd1;
                end
            end else if (accept && mispredict) begin
                state_q     <= ST_DRAIN;
                drain_cnt_q <= DRAIN_LOAD;
            end
        end
    end

    assign o_busy_drain       = (state_q == ST_DRAIN);
    assign o_cf_count         = cf_count_q;
    assign o_mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed and short random stimulus for branch_resolve_unit. A second
// instance with UPDATE_JALR=0 shares the same inputs, and only its update
// strobe is checked. Expected outputs come from a behavioural model. They
// are pushed to exp_q when a cycle is driven, then popped and compared
// after the clock edge.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, stall, flush, is_jalr, is_comp, btb_hit, pred_tk, act_tk;
    logic [31:0] pc, pred_tgt, act_tgt;

    logic        upd, upd_tk, mis, busy;
    logic [31:0] upd_pc, upd_tgt, redir, cf_cnt, mis_cnt;

    logic        nj_upd, nj_upd_tk, nj_mis, nj_busy;
    logic [31:0] nj_upd_pc, nj_upd_tgt, nj_redir, nj_cf_cnt, nj_mis_cnt;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .DRAIN_CYCLES(DRAIN), .UPDATE_JALR(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_is_jalr(is_jalr), .i_is_compressed(is_comp), .i_pc(pc), .i_btb_hit(btb_hit),
        .i_predicted_taken(pred_tk), .i_predicted_target(pred_tgt),
        .i_actual_taken(act_tk), .i_actual_target(act_tgt),
        .o_update(upd), .o_update_pc(upd_pc), .o_update_target(upd_tgt),
        .o_update_taken(upd_tk), .o_mispredict(mis), .o_redirect_pc(redir),
        .o_busy_drain(busy), .o_cf_count(cf_cnt), .o_mispredict_count(mis_cnt)
    );

    branch_resolve_unit #(.XLEN(32), .DRAIN_CYCLES(DRAIN), .UPDATE_JALR(1'b0)) dut_nj (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_is_jalr(is_jalr), .i_is_compressed(is_comp), .i_pc(pc), .i_btb_hit(btb_hit),
        .i_predicted_taken(pred_tk), .i_predicted_target(pred_tgt),
        .i_actual_taken(act_tk), .i_actual_target(act_tgt),
        .o_update(nj_upd), .o_update_pc(nj_upd_pc), .o_update_target(nj_upd_tgt),
        .o_update_taken(nj_upd_tk), .o_mispredict(nj_mis), .o_redirect_pc(nj_redir),
        .o_busy_drain(nj_busy), .o_cf_count(nj_cf_cnt), .o_mispredict_count(nj_mis_cnt)
    );

    typedef struct packed {
        logic        upd;
        logic        upd_nj;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utk;
        logic        mis;
        logic [31:0] redir;
        logic        busy;
        logic [31:0] cf;
        logic [31:0] mc;
    } exp_t;

    exp_t exp_q[$];

    // Model state
    logic [31:0] m_upc, m_utgt, m_redir, m_cf, m_mc;
    logic        m_utk;
    int          m_left;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_upc = '0; m_utgt = '0; m_redir = '0; m_cf = '0; m_mc = '0;
        m_utk = 1'b0; m_left = 0;
    endtask

    // Reset with a mispredicting instruction presented, to show reset wins.
    task automatic do_reset();
        rst = 1'b1; valid = 1'b1; stall = 1'b0; flush = 1'b0; is_jalr = 1'b0;
        is_comp = 1'b0; pc = 32'h10; btb_hit = 1'b1; pred_tk = 1'b1;
        pred_tgt = 32'h20; act_tk = 1'b0; act_tgt = 32'h30;
        @(posedge clk); #1;
        chk("rst_update", {31'd0, upd}, 32'd0);
        chk("rst_update_pc", upd_pc, 32'd0);
        chk("rst_update_target", upd_tgt, 32'd0);
        chk("rst_update_taken", {31'd0, upd_tk}, 32'd0);
        chk("rst_mispredict", {31'd0, mis}, 32'd0);
        chk("rst_redirect_pc", redir, 32'd0);
        chk("rst_busy_drain", {31'd0, busy}, 32'd0);
        chk("rst_cf_count", cf_cnt, 32'd0);
        chk("rst_mispredict_count", mis_cnt, 32'd0);
        rst = 1'b0; valid = 1'b0;
        model_clear();
    endtask

    // One clock: drive inputs, predict outputs, then compare after the edge.
    task automatic step(input string tag, input logic v, input logic st, input logic fl,
                        input logic jr, input logic cm, input logic [31:0] p,
                        input logic hit, input logic pt, input logic [31:0] ptg,
                        input logic at, input logic [31:0] atg);
        exp_t e;
        logic acc, mp;
        valid = v; stall = st; flush = fl; is_jalr = jr; is_comp = cm; pc = p;
        btb_hit = hit; pred_tk = pt; pred_tgt = ptg; act_tk = at; act_tgt = atg;

        acc = v && !st && !fl && (m_left == 0);
        mp  = acc && ((pt != at) || (pt && at && (ptg != atg)));
        e.upd    = acc && (at || hit);
        e.upd_nj = acc && (at || hit) && !jr;
        if (e.upd) begin
            m_upc = p; m_utgt = atg; m_utk = at;
        end
        e.mis = mp;
        if (mp) m_redir = at ? atg : (p + (cm ? 32'd2 : 32'd4));
        if (acc && m_cf != 32'hFFFF_FFFF) m_cf = m_cf + 1;
        if (mp && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
        if (fl) m_left = 0;
        else if (m_left > 0) m_left = m_left - 1;
        else if (mp) m_left = DRAIN;
        e.upc = m_upc; e.utgt = m_utgt; e.utk = m_utk; e.redir = m_redir;
        e.busy = (m_left > 0); e.cf = m_cf; e.mc = m_mc;
        exp_q.push_back(e);

        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk({tag, ".update"}, {31'd0, upd}, {31'd0, e.upd});
        chk({tag, ".update_nojalr"}, {31'd0, nj_upd}, {31'd0, e.upd_nj});
        chk({tag, ".update_pc"}, upd_pc, e.upc);
        chk({tag, ".update_target"}, upd_tgt, e.utgt);
        chk({tag, ".update_taken"}, {31'd0, upd_tk}, {31'd0, e.utk});
        chk({tag, ".mispredict"}, {31'd0, mis}, {31'd0, e.mis});
        chk({tag, ".redirect_pc"}, redir, e.redir);
        chk({tag, ".busy_drain"}, {31'd0, busy}, {31'd0, e.busy});
        chk({tag, ".cf_count"}, cf_cnt, e.cf);
        chk({tag, ".mispredict_count"}, mis_cnt, e.mc);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        model_clear();
        do_reset();

        // Correct taken prediction
        step("correct", 1, 0, 0, 0, 0, 32'h100, 1, 1, 32'h200, 1, 32'h200);
        idle("hold_after_correct");

        // Direction mispredict, compressed, then two wrong-path instructions
        step("dir_mis", 1, 0, 0, 0, 1, 32'h100, 1, 1, 32'h200, 0, 32'h200);
        step("wrong_path1", 1, 0, 0, 0, 0, 32'h700, 1, 1, 32'h800, 0, 32'h0);
        step("wrong_path2", 1, 1, 0, 0, 0, 32'h704, 0, 0, 32'h0, 1, 32'h900);
        step("after_drain", 1, 0, 0, 0, 0, 32'h300, 1, 1, 32'h340, 1, 32'h340);

        // JALR target mispredict
        step("jalr_tgt_mis", 1, 0, 0, 1, 0, 32'h40, 1, 1, 32'h80, 1, 32'h90);
        idle("jalr_drain1");
        idle("jalr_drain2");

        // Not-taken branch, BTB miss, correct: counts but never allocates
        step("nt_miss", 1, 0, 0, 0, 0, 32'h500, 0, 0, 32'h0, 0, 32'h520);

        // Stalled for three cycles, then accepted once
        for (int i = 0; i < 3; i++)
            step("stalled", 1, 1, 0, 0, 0, 32'h600, 1, 1, 32'h640, 1, 32'h640);
        step("unstalled", 1, 0, 0, 0, 0, 32'h600, 1, 1, 32'h640, 1, 32'h640);
        idle("after_stall");

        // Mispredict killed by a flush
        step("flush_mis", 1, 0, 1, 0, 0, 32'h800, 1, 1, 32'h900, 0, 32'h0);
        idle("after_flush");

        // Flush during DRAIN releases the unit at once
        step("mis_pre_flush", 1, 0, 0, 0, 0, 32'hA00, 1, 0, 32'h0, 1, 32'hB00);
        step("flush_in_drain", 0, 0, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        step("post_flush_acc", 1, 0, 0, 0, 0, 32'hC00, 1, 1, 32'hC40, 1, 32'hC40);

        // Fallthrough wraps past the top of the address space
        step("wrap", 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 1, 32'h10, 0, 32'h10);
        idle("wrap_drain1");
        idle("wrap_drain2");

        // Short random run
        for (int i = 0; i < 40; i++) begin
            logic [31:0] tg;
            logic        ptk;
            tg  = 32'h1000 + 32'($urandom_range(0, 3)) * 4;
            ptk = 1'($urandom_range(0, 1));
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFE,
                 1'($urandom_range(0, 1)), ptk, tg,
                 1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 3)) * 4);
        end
        idle("rand_tail1");
        idle("rand_tail2");

        // Saturation of the control-transfer counter
        force dut.cf_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.cf_count_q;
        m_cf = 32'hFFFF_FFFF;
        step("saturate", 1, 0, 0, 0, 0, 32'h2000, 1, 1, 32'h2100, 1, 32'h2100);
        idle("saturate_hold");

        // Reset in the middle of DRAIN
        step("mis_pre_reset", 1, 0, 0, 0, 0, 32'h3000, 1, 1, 32'h3100, 0, 32'h0);
        do_reset();
        step("post_reset_acc", 1, 0, 0, 0, 0, 32'h4000, 1, 1, 32'h4100, 1, 32'h4100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Guard against a hung simulation.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
